div_seq_ctrl: RTL

- Multi-cycle divide sequencer for DIV/DIVU. It takes operands and a start pulse-level from the EX stage and runs a radix-2 restoring divide, one quotient bit per cycle.
- It handles signed pre- and post-correction and returns {remainder, quotient} with a ready flag, which EX writes into HI/LO.
- It owns the divider FSM, the bit counter and annul handling. EX keeps its divide stall request asserted until ready_o is seen.

---
 rtl/div_seq_ctrl_pkg.sv | 14 +
 rtl/div_seq_ctrl_step.sv | 15 +
 rtl/div_seq_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/div_seq_ctrl_pkg.sv
// div_seq_ctrl_pkg: shared state codes, handshake levels and bus widths for the divider
package div_seq_ctrl_pkg;
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam int   REG_W                = 32;
endpackage

// File: rtl/div_seq_ctrl_step.sv
// div_step: one radix-2 restoring divide step producing one quotient bit
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic              bit_i,
    input  logic [DATA_W-1:0] dvs_i,
    output logic [DATA_W-1:0] rem_o,
    output logic              q_o
);
    logic [DATA_W:0] trial;
    assign trial = {rem_i, bit_i};
    assign q_o   = trial >= {1'b0, dvs_i};
    assign rem_o = q_o ? DATA_W'(trial - {1'b0, dvs_i}) : trial[DATA_W-1:0];
endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle signed/unsigned restoring divide sequencer returning {rem, quo}
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int DATA_W = REG_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                annul_i,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);
    localparam int CW = $clog2(DATA_W) + 1;
    div_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [DATA_W-1:0]   dq_q, dvs_q, rem_q, rem_n, quo_n;
    logic                q_neg_q, r_neg_q, q_bit, sign1, sign2, last;
    logic [2*DATA_W-1:0] fin;

    assign sign1 = signed_div_i & opdata1_i[DATA_W-1];
    assign sign2 = signed_div_i & opdata2_i[DATA_W-1];
    assign last  = cnt_q == CW'(DATA_W - 1);
    assign quo_n = {dq_q[DATA_W-2:0], q_bit};
    assign fin   = {r_neg_q ? -rem_n : rem_n, q_neg_q ? -quo_n : quo_n};

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem_i(rem_q),
        .bit_i(dq_q[DATA_W-1]),
        .dvs_i(dvs_q),
        .rem_o(rem_n),
        .q_o  (q_bit)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= DIV_FREE;
        else     state_q <= state_d;
    end

    // next state: annul always wins back to FREE; start only matters in FREE and END
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_FREE:    if (start_i == DIV_START && !annul_i)
                             state_d = opdata2_i == '0 ? DIV_BY_ZERO : DIV_ON;
            DIV_BY_ZERO: state_d = annul_i ? DIV_FREE : DIV_END;
            DIV_ON:      state_d = annul_i ? DIV_FREE : last ? DIV_END : DIV_ON;
            DIV_END:     if (start_i == DIV_STOP || annul_i) state_d = DIV_FREE;
            default:     state_d = DIV_FREE;
        endcase
    end

    // datapath: dq_q holds the dividend bits still to consume and collects quotient bits from the bottom
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            dq_q     <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            if (state_q == DIV_FREE && state_d == DIV_ON) begin
                dq_q    <= sign1 ? -opdata1_i : opdata1_i;
                dvs_q   <= sign2 ? -opdata2_i : opdata2_i;
                q_neg_q <= sign1 ^ sign2;
                r_neg_q <= sign1;
                rem_q   <= '0;
                cnt_q   <= '0;
            end else if (state_q == DIV_ON && !annul_i) begin
                dq_q    <= quo_n;
                rem_q   <= rem_n;
                cnt_q   <= cnt_q + CW'(1);
            end
            ready_o  <= state_d == DIV_END ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
            result_o <= state_d != DIV_END ? '0 : state_q == DIV_ON ? fin : result_o;
        end
    end
endmodule
